// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, one bit per
// cycle, followed by a sign-fix cycle. Divide-by-zero and signed overflow skip the
// iteration and go straight to the fix cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    // Multiply: running product. Divide: {remainder, quotient/dividend}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   amag_q, amag_d;
    logic [WIDTH-1:0]   bmag_q, bmag_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;    // negate product / quotient
    logic               aneg_q, aneg_d;  // dividend negative: negate remainder
    logic               spec_q, spec_d;  // fast path: acc low half already holds the answer
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               in_asigned, in_bsigned, in_aneg, in_bneg;
    logic [WIDTH-1:0]   in_amag, in_bmag;
    logic               in_divzero, in_ovf;
    logic [WIDTH-1:0]   in_fast_res;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   fix_res;
    logic [2*WIDTH-1:0] prod_s;

    // Decode the incoming request: operand signedness, magnitudes and special cases.
    always_comb begin
        in_asigned  = ~(op[0] & (op[1] | op[2]));
        in_bsigned  = (op == 3'b000) | (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
        in_aneg     = in_asigned & opa[WIDTH-1];
        in_bneg     = in_bsigned & opb[WIDTH-1];
        in_amag     = in_aneg ? -opa : opa;
        in_bmag     = in_bneg ? -opb : opb;
        in_divzero  = op[2] & (opb == '0);
        in_ovf      = op[2] & ~op[0] & (opa == {1'b1, {(WIDTH-1){1'b0}}}) & (opb == '1);
        in_fast_res = '0;
        if (in_divzero) begin
            in_fast_res = op[1] ? opa : '1;
        end else if (in_ovf) begin
            in_fast_res = op[1] ? '0 : opa;
        end
    end

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? amag_q : '0)};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, bmag_q};
        div_next  = {(div_ge ? (div_shift[WIDTH-1:0] - bmag_q) : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
    end

    // Sign correction and half selection for the final result.
    always_comb begin
        prod_s = neg_q ? -acc_q : acc_q;
        case (op_q)
            3'b000:                 fix_res = prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            default:                fix_res = aneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                                                     : acc_q[2*WIDTH-1:WIDTH];
        endcase
        if (spec_q) begin
            fix_res = acc_q[WIDTH-1:0];
        end
    end

    // Next-state logic for the IDLE/CALC/FIX sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        amag_d   = amag_q;
        bmag_d   = bmag_q;
        op_d     = op_q;
        neg_d    = neg_q;
        aneg_d   = aneg_q;
        spec_d   = spec_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                // flush wins over a simultaneous start
                if (start && !flush) begin
                    op_d   = op;
                    amag_d = in_amag;
                    bmag_d = in_bmag;
                    neg_d  = in_aneg ^ in_bneg;
                    aneg_d = in_aneg;
                    cnt_d  = '0;
                    if (in_divzero || in_ovf) begin
                        spec_d  = 1'b1;
                        acc_d   = {{WIDTH{1'b0}}, in_fast_res};
                        state_d = StFix;
                    end else begin
                        spec_d  = 1'b0;
                        acc_d   = {{WIDTH{1'b0}}, (op[2] ? in_amag : in_bmag)};
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!flush) begin
                    result_d = fix_res;
                    done_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            amag_q   <= '0;
            bmag_q   <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            aneg_q   <= 1'b0;
            spec_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            amag_q   <= amag_d;
            bmag_q   <= bmag_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            aneg_q   <= aneg_d;
            spec_q   <= spec_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = result_q;

endmodule
